// File: rtl/io_term_port.sv
// Device-side programmed-I/O terminal port: keyboard FIFO feeding INPR/FGI and
// an OUTR/FGO FIFO feeding the printer. Optional error counter: IO_OVR_CNT_EN.
module io_term_port #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_valid,
  output logic       kb_ready,
  output logic [7:0] inpt,
  output logic       fgi,
  input  logic       inp_ack,
  input  logic [7:0] outr,
  input  logic       out_load,
  output logic       fgo,
  output logic [7:0] prt_data,
  output logic       prt_valid,
  input  logic       prt_ready,
  input  logic       ien_set,
  input  logic       ien_clr,
  output logic       irq
`ifdef IO_OVR_CNT_EN
  ,
  output logic [7:0] ovr_cnt
`endif
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;

  logic [7:0]     in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr, in_rd;
  logic [ICW-1:0] in_cnt, in_cnt_nxt;
  logic           in_push, in_pop;

  logic [7:0]     out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr, out_rd;
  logic [OCW-1:0] out_cnt, out_cnt_nxt;
  logic           out_push, out_pop;

  logic           ien;

  // Input path: keyboard -> processor INPR
  assign kb_ready = (in_cnt != ICW'(IN_DEPTH));
  assign fgi      = (in_cnt != '0);
  assign inpt     = fgi ? in_mem[in_rd] : 8'h00;
  assign in_push  = kb_valid & kb_ready;
  assign in_pop   = inp_ack & fgi;

  // Output path: processor OUTR -> printer
  assign fgo       = (out_cnt != OCW'(OUT_DEPTH));
  assign prt_valid = (out_cnt != '0);
  assign prt_data  = prt_valid ? out_mem[out_rd] : 8'h00;
  assign out_push  = out_load & fgo;
  assign out_pop   = prt_valid & prt_ready;

  assign irq = ien & (fgi | fgo);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    if (in_push && !in_pop)
      in_cnt_nxt = in_cnt + 1'b1;
    else if (!in_push && in_pop)
      in_cnt_nxt = in_cnt - 1'b1;
    if (out_push && !out_pop)
      out_cnt_nxt = out_cnt + 1'b1;
    else if (!out_push && out_pop)
      out_cnt_nxt = out_cnt - 1'b1;
  end

  // NOTE: storage arrays are not reset; the cleared counts already hide stale contents.
  always_ff @(posedge clk) begin
    if (in_push)
      in_mem[in_wr] <= kb_data;
    if (out_push)
      out_mem[out_wr] <= outr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr   <= '0;
      in_rd   <= '0;
      in_cnt  <= '0;
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
      ien     <= 1'b0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      in_cnt  <= in_cnt_nxt;
      out_cnt <= out_cnt_nxt;
      if (ien_clr)
        ien <= 1'b0;
      else if (ien_set)
        ien <= 1'b1;
    end
  end

`ifdef IO_OVR_CNT_EN
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign err_inc = {1'b0, out_load & ~fgo} + {1'b0, inp_ack & ~fgi};
  assign err_sum = {1'b0, ovr_cnt} + {7'b0, err_inc};

  // Saturates at 8'hFF rather than wrapping
  always_ff @(posedge clk) begin
    if (rst)
      ovr_cnt <= 8'h00;
    else
      ovr_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_io_term_port.sv
// Self-checking bench for io_term_port: vector table for the input path,
// a behavioural model with byte scoreboards checked on every cycle.
module tb_io_term_port;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] kb_data;
  logic       kb_valid;
  logic       kb_ready;
  logic [7:0] inpt;
  logic       fgi;
  logic       inp_ack;
  logic [7:0] outr;
  logic       out_load;
  logic       fgo;
  logic [7:0] prt_data;
  logic       prt_valid;
  logic       prt_ready;
  logic       ien_set;
  logic       ien_clr;
  logic       irq;
`ifdef IO_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  io_term_port #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .kb_data  (kb_data),
    .kb_valid (kb_valid),
    .kb_ready (kb_ready),
    .inpt     (inpt),
    .fgi      (fgi),
    .inp_ack  (inp_ack),
    .outr     (outr),
    .out_load (out_load),
    .fgo      (fgo),
    .prt_data (prt_data),
    .prt_valid(prt_valid),
    .prt_ready(prt_ready),
    .ien_set  (ien_set),
    .ien_clr  (ien_clr),
    .irq      (irq)
`ifdef IO_OVR_CNT_EN
    ,
    .ovr_cnt  (ovr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  bit         ien_m;
  int         exp_ovr;

  typedef struct {
    logic       kv;
    logic [7:0] kd;
    logic       ack;
    logic       e_rdy;
    logic       e_fgi;
    logic [7:0] e_inpt;
  } in_vec_t;

  in_vec_t vec [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [7:0] e_inpt;
    logic [7:0] e_prt;
    bit         e_fgi;
    bit         e_fgo;
    e_fgi  = (in_q.size() != 0);
    e_fgo  = (out_q.size() < OUT_DEPTH);
    e_inpt = e_fgi ? in_q[0] : 8'h00;
    e_prt  = (out_q.size() != 0) ? out_q[0] : 8'h00;
    check("m_fgi", 32'(fgi), 32'(e_fgi));
    check("m_kb_ready", 32'(kb_ready), 32'(in_q.size() < IN_DEPTH));
    check("m_inpt", 32'(inpt), 32'(e_inpt));
    check("m_fgo", 32'(fgo), 32'(e_fgo));
    check("m_prt_valid", 32'(prt_valid), 32'(out_q.size() != 0));
    check("m_prt_data", 32'(prt_data), 32'(e_prt));
    check("m_irq", 32'(irq), 32'(ien_m && (e_fgi || e_fgo)));
`ifdef IO_OVR_CNT_EN
    check("m_ovr_cnt", 32'(ovr_cnt), 32'(exp_ovr));
`endif
  endtask

  // Applies the currently driven inputs for one edge, updating the model
  task automatic step_all();
    bit in_push, in_pop, out_push, out_pop;
    if (rst) begin
      in_q.delete();
      out_q.delete();
      ien_m   = 1'b0;
      exp_ovr = 0;
    end else begin
      in_push  = kb_valid && (in_q.size() < IN_DEPTH);
      in_pop   = inp_ack && (in_q.size() > 0);
      out_push = out_load && (out_q.size() < OUT_DEPTH);
      out_pop  = prt_ready && (out_q.size() > 0);
      if (inp_ack && in_q.size() == 0) exp_ovr++;
      if (out_load && out_q.size() == OUT_DEPTH) exp_ovr++;
      if (exp_ovr > 255) exp_ovr = 255;
      if (in_pop) begin
        check("sb_inpt", 32'(inpt), 32'(in_q[0]));
        void'(in_q.pop_front());
      end
      if (out_pop) begin
        check("sb_prt_data", 32'(prt_data), 32'(out_q[0]));
        void'(out_q.pop_front());
      end
      if (in_push) in_q.push_back(kb_data);
      if (out_push) out_q.push_back(outr);
      if (ien_clr) ien_m = 1'b0;
      else if (ien_set) ien_m = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst = 1'b1; kb_data = 8'h00; kb_valid = 1'b0; inp_ack = 1'b0;
    outr = 8'h00; out_load = 1'b0; prt_ready = 1'b0;
    ien_set = 1'b0; ien_clr = 1'b0;
    exp_ovr = 0; ien_m = 1'b0;

    //            kv    kd     ack   rdy   fgi   inpt
    vec[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41};
    vec[1]  = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h41};
    vec[2]  = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 8'h41};
    vec[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h41};
    vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h42};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h43};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vec[9]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41};
    vec[10] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h41};
    vec[11] = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 8'h41};
    vec[12] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h41};
    vec[13] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h42};
    vec[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h42};
    vec[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h43};
    vec[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44};
    vec[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55};
    vec[18] = '{1'b1, 8'h60, 1'b1, 1'b1, 1'b1, 8'h60};
    vec[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    // Reset, then idle
    step_all();
    step_all();
    rst = 1'b0;
    step_all();
    check("rst_fgi", 32'(fgi), 32'd0);
    check("rst_fgo", 32'(fgo), 32'd1);
    check("rst_kb_ready", 32'(kb_ready), 32'd1);
    check("rst_prt_valid", 32'(prt_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_inpt", 32'(inpt), 32'h00);

    ien_set = 1'b1;
    step_all();
    ien_set = 1'b0;
    check("ion_irq", 32'(irq), 32'd1);

    // Input path vectors
    for (int i = 0; i < 20; i++) begin
      kb_valid = vec[i].kv;
      kb_data  = vec[i].kd;
      inp_ack  = vec[i].ack;
      step_all();
      check($sformatf("vec%0d_kb_ready", i), 32'(kb_ready), 32'(vec[i].e_rdy));
      check($sformatf("vec%0d_fgi", i), 32'(fgi), 32'(vec[i].e_fgi));
      check($sformatf("vec%0d_inpt", i), 32'(inpt), 32'(vec[i].e_inpt));
    end
    kb_valid = 1'b0;
    inp_ack  = 1'b0;

    // Output path: printer stalled, five loads, fifth dropped
    prt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      outr     = 8'h10 + 8'(i);
      out_load = 1'b1;
      step_all();
      out_load = 1'b0;
      check($sformatf("load%0d_fgo", i), 32'(fgo), (i < 3) ? 32'd1 : 32'd0);
      if (i == 0) check("load_latency_prt_valid", 32'(prt_valid), 32'd1);
    end
`ifdef IO_OVR_CNT_EN
    check("ovr_after_drop", 32'(ovr_cnt), 32'd2);
`endif
    check("irq_fgi0_fgo0", 32'(irq), 32'd0);
    step_all();
    check("prt_hold", 32'(prt_data), 32'h10);

    prt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("prt_seq%0d", i), 32'(prt_data), 32'h10 + 32'(i));
      step_all();
    end
    check("prt_drained", 32'(prt_valid), 32'd0);

    // Simultaneous output push and pop
    outr = 8'h20; out_load = 1'b1;
    step_all();
    outr = 8'h21;
    step_all();
    out_load = 1'b0;
    check("pushpop_valid", 32'(prt_valid), 32'd1);
    check("pushpop_data", 32'(prt_data), 32'h21);
    step_all();
    check("pushpop_empty", 32'(prt_valid), 32'd0);
    prt_ready = 1'b0;

    // Interrupt enable priority and masking
    ien_set = 1'b1; ien_clr = 1'b1;
    step_all();
    ien_set = 1'b0; ien_clr = 1'b0;
    check("ien_clr_wins", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) begin
      outr = 8'h30 + 8'(i); out_load = 1'b1;
      step_all();
    end
    out_load = 1'b0;
    check("out_full_fgo", 32'(fgo), 32'd0);
    ien_set = 1'b1;
    step_all();
    ien_set = 1'b0;
    check("irq_masked_no_flags", 32'(irq), 32'd0);
    out_load = 1'b1; inp_ack = 1'b1;
    step_all();
    out_load = 1'b0; inp_ack = 1'b0;
`ifdef IO_OVR_CNT_EN
    check("ovr_double", 32'(ovr_cnt), 32'd4);
`endif
    kb_data = 8'h77; kb_valid = 1'b1;
    step_all();
    kb_valid = 1'b0;
    check("irq_on_kb", 32'(irq), 32'd1);
    check("kb_77", 32'(inpt), 32'h77);

    // Reset with data in both FIFOs
    kb_data = 8'h78; kb_valid = 1'b1; rst = 1'b1;
    step_all();
    rst = 1'b0; kb_valid = 1'b0;
    check("mid_rst_fgi", 32'(fgi), 32'd0);
    check("mid_rst_inpt", 32'(inpt), 32'h00);
    check("mid_rst_fgo", 32'(fgo), 32'd1);
    check("mid_rst_prt_valid", 32'(prt_valid), 32'd0);
    check("mid_rst_prt_data", 32'(prt_data), 32'h00);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_kb_ready", 32'(kb_ready), 32'd1);
    prt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_all();
      check("post_rst_no_prt", 32'(prt_valid), 32'd0);
      check("post_rst_no_fgi", 32'(fgi), 32'd0);
    end
    kb_data = 8'h99; kb_valid = 1'b1;
    step_all();
    kb_valid = 1'b0;
    check("post_rst_new_byte", 32'(inpt), 32'h99);
    inp_ack = 1'b1;
    step_all();
    inp_ack = 1'b0;
    check("post_rst_drained", 32'(fgi), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
